// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, DBIT data bits, LSB first, SB_TICK stop ticks.
// Define UART_RX_PARITY_EN to insert an even-parity bit and the o_parity_err output.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_tick,
  input  logic            i_rx,
  output logic [DBIT-1:0] o_dout,
  output logic            o_rx_done,
  output logic            o_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            o_parity_err
`endif
);

  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            rx_q1;
  logic            rx_s;
`ifdef UART_RX_PARITY_EN
  logic            par_ok;
`endif

  // NOTE: synchronizer flops reset to 1 so a reset release never looks like a start edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= i_rx;
      rx_s  <= rx_q1;
    end
  end

  // NOTE: all state uses non-blocking assignment so every branch sees pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      s           <= '0;
      n           <= '0;
      b           <= '0;
      o_dout      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
      par_ok       <= 1'b1;
`endif
    end else begin
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end

        START: begin
          if (i_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        DATA: begin
          if (i_tick) begin
            if (s == S_BIT) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (i_tick) begin
            if (s == S_BIT) begin
              s      <= '0;
              par_ok <= ~^{b, rx_s};
              state  <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (i_tick) begin
            if (s == S_STOP) begin
              state <= IDLE;
              if (!rx_s) begin
                o_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (!par_ok) begin
                o_parity_err <= 1'b1;
`endif
              end else begin
                o_dout    <= b;
                o_rx_done <= 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame-level reference model queues expected events,
// a negedge monitor pops and compares each pulse the receiver produces.
module tb_uart_rx;

  localparam int DBIT = 8;
  localparam logic [2:0] K_DONE = 3'b001;
  localparam logic [2:0] K_FERR = 3'b010;
  localparam logic [2:0] K_PERR = 3'b100;

  typedef struct {
    logic [2:0]      kind;
    logic [DBIT-1:0] dout;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            i_tick;
  logic            i_rx = 1'b1;
  logic [DBIT-1:0] o_dout;
  logic            o_rx_done;
  logic            o_frame_err;
  logic            o_parity_err;

  exp_t            exp_q[$];
  logic [DBIT-1:0] model_dout = '0;
  int              checks = 0;
  int              errors = 0;
  int              tick_cnt = 0;

  uart_rx #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_tick      (i_tick),
    .i_rx        (i_rx),
    .o_dout      (o_dout),
    .o_rx_done   (o_rx_done),
    .o_frame_err (o_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(o_parity_err)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign o_parity_err = 1'b0;
`endif

  always #5 clock = ~clock;

  // One tick every 4 clocks.
  always @(posedge clock) tick_cnt <= (tick_cnt + 1) % 4;
  assign i_tick = (tick_cnt == 3);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_ticks(input int cnt);
    repeat (cnt) begin
      do @(posedge clock); while (i_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic send_bit(input logic v, input int ticks);
    i_rx = v;
    wait_ticks(ticks);
  endtask

  // Reference model: outcome of a whole frame from the line-level rules.
  task automatic send_frame(input logic [DBIT-1:0] d, input logic stop_ok, input logic par);
    exp_t e;
    logic bad_par;
    bad_par = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_par = ^{d, par};
`endif
    if (!stop_ok)     e.kind = K_FERR;
    else if (bad_par) e.kind = K_PERR;
    else begin
      e.kind     = K_DONE;
      model_dout = d;
    end
    e.dout = model_dout;
    exp_q.push_back(e);

    send_bit(1'b0, 16);
    for (int i = 0; i < DBIT; i++) send_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
    send_bit(par, 16);
`endif
    if (stop_ok) send_bit(1'b1, 16);
    else begin
      // Low stop covers the mid sample but ends before a false start could qualify.
      send_bit(1'b0, 12);
      send_bit(1'b1, 20);
    end
  endtask

  always @(negedge clock) begin
    if (reset && (o_rx_done || o_frame_err || o_parity_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, o_parity_err, o_frame_err, o_rx_done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_kind", {29'd0, o_parity_err, o_frame_err, o_rx_done}, {29'd0, e.kind});
        check("dout", {24'd0, o_dout}, {24'd0, e.dout});
      end
    end
  end

  initial begin
    logic [DBIT-1:0] d;
    logic            ok;
    logic            p;

    repeat (5) @(posedge clock);
    #1;
    check("reset_dout", {24'd0, o_dout}, 32'd0);
    check("reset_done", {31'd0, o_rx_done}, 32'd0);
    check("reset_ferr", {31'd0, o_frame_err}, 32'd0);
    reset = 1'b1;
    wait_ticks(4);

    send_frame(8'h55, 1'b1, ^8'h55);
    send_frame(8'hA3, 1'b1, ^8'hA3);
    send_frame(8'h0F, 1'b1, ^8'h0F);

    // Short low glitch on an idle line must be rejected silently.
    send_bit(1'b0, 3);
    send_bit(1'b1, 20);

    send_frame(8'hC4, 1'b0, ^8'hC4);
    wait_ticks(4);

    // Abort a 0xFF frame with reset in the middle of data bit 4.
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
    send_bit(1'b1, 8);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("midreset_dout", {24'd0, o_dout}, 32'd0);
    check("midreset_done", {31'd0, o_rx_done}, 32'd0);
    reset = 1'b1;
    model_dout = '0;
    send_bit(1'b1, 8 + 16 * 4);
    wait_ticks(10);
    send_frame(8'h12, 1'b1, ^8'h12);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
`endif

    for (int k = 0; k < 20; k++) begin
      d  = DBIT'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      p  = ^d ^ ($urandom_range(0, 4) == 0);
      send_frame(d, ok, p);
      wait_ticks($urandom_range(0, 10));
    end

    wait_ticks(20);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clock);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
